// File: rtl/button_debounce.sv
// button_debounce: per-channel 2-flop synchronizer followed by a 4-state
// debounce FSM. Outputs are the registered debounced level and a one-cycle
// press pulse. Optional auto-repeat of the press pulse is enabled by defining
// the macro BUTTON_AUTO_REPEAT_EN; without it REPEAT_CYCLES has no effect.
module button_debounce #(
    parameter int unsigned NUM_BUTTONS     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] key_n,
    output logic [NUM_BUTTONS-1:0] button,
    output logic [NUM_BUTTONS-1:0] button_press
);

    localparam int unsigned CNT_W = 24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter values the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'h00FF_FFFF) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES out of range 2..2^24-1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("button_debounce: REPEAT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [NUM_BUTTONS-1:0] sync1_q;
    logic [NUM_BUTTONS-1:0] sync2_q;
    logic [NUM_BUTTONS-1:0] button_q;
    logic [NUM_BUTTONS-1:0] press_q;
    state_t                 state_q [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_q   [NUM_BUTTONS];

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q [NUM_BUTTONS];
`endif

    // Two-flop synchronizer; stores the pressed (inverted) polarity so that
    // the reset value 0 means "key released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce FSM with registered level and press pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
                rpt_q[i]   <= '0;
`endif
            end
            button_q <= '0;
            press_q  <= '0;
        end else begin
            press_q <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                case (state_q[i])
                    RELEASED: begin
                        if (sync2_q[i]) begin
                            state_q[i] <= PRESS_WAIT;
                            cnt_q[i]   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= RELEASED;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_q[i]  <= PRESSED;
                            button_q[i] <= 1'b1;
                            press_q[i]  <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                            rpt_q[i]    <= '0;
`endif
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= RELEASE_WAIT;
                            cnt_q[i]   <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
                            rpt_q[i]   <= '0;
`endif
                        end
`ifdef BUTTON_AUTO_REPEAT_EN
                        else if (rpt_q[i] == RPT_LAST) begin
                            rpt_q[i]   <= '0;
                            press_q[i] <= 1'b1;
                        end else begin
                            rpt_q[i] <= rpt_q[i] + RPT_W'(1);
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        if (sync2_q[i]) begin
                            state_q[i] <= PRESSED;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_q[i]  <= RELEASED;
                            button_q[i] <= 1'b0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q[i] <= RELEASED;
                    end
                endcase
            end
        end
    end

    assign button       = button_q;
    assign button_press = press_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with DEBOUNCE_CYCLES=8 and REPEAT_CYCLES=20.
module tb_button_debounce;

    localparam int NB  = 2;
    localparam int DEB = 8;
    localparam int RPT = 20;
    localparam int NV  = 12;

    logic          clk;
    logic          reset;
    logic [NB-1:0] key_n;
    logic [NB-1:0] button;
    logic [NB-1:0] button_press;

    button_debounce #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .button      (button),
        .button_press(button_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int fail_prints = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int pc [NB];
    int press_times [$];

    typedef struct {
        logic [NB-1:0] key_n;
        int            cycles;
        logic [NB-1:0] exp_btn;
        int            exp_press;
    } vec_t;

    vec_t vecs [NV];

    // Reference model: a channel flips its level once DEB+1 consecutive
    // synchronized samples disagree with the current level.
    logic [NB-1:0] m_s1 = '0;
    logic [NB-1:0] m_s2 = '0;
    logic [NB-1:0] m_btn = '0;
    logic [NB-1:0] m_press = '0;
    int            m_run [NB] = '{0, 0};
    int            m_rpt [NB] = '{0, 0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1    <= '0;
            m_s2    <= '0;
            m_btn   <= '0;
            m_press <= '0;
            for (int i = 0; i < NB; i++) begin
                m_run[i] <= 0;
                m_rpt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                logic raw;
                logic b;
                logic pr;
                int   r;
                int   p;
                raw = m_s2[i];
                b   = m_btn[i];
                r   = m_run[i];
                p   = m_rpt[i];
                pr  = 1'b0;
                r   = (raw != b) ? r + 1 : 0;
                if (r == DEB + 1) begin
                    b = raw;
                    r = 0;
                    if (raw) begin
                        pr = 1'b1;
                        p  = 0;
                    end
                end
`ifdef BUTTON_AUTO_REPEAT_EN
                else if (b) begin
                    if (!raw) begin
                        p = -1;
                    end else begin
                        p = p + 1;
                        if (p == RPT) begin
                            pr = 1'b1;
                            p  = 0;
                        end
                    end
                end
`endif
                m_run[i]   <= r;
                m_rpt[i]   <= p;
                m_btn[i]   <= b;
                m_press[i] <= pr;
            end
            m_s1 <= ~key_n;
            m_s2 <= m_s1;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (button !== m_btn || button_press !== m_press) begin
                failures++;
                if (fail_prints < 40) begin
                    fail_prints++;
                    $display("FAIL model_cmp cyc=%0d: button=%b press=%b, model button=%b press=%b",
                             cyc, button, button_press, m_btn, m_press);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < NB; i++) pc[i] += int'(button_press[i]);
            if (button_press[0]) press_times.push_back(cyc);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NB; i++) pc[i] = 0;
        press_times.delete();
    endtask

    task automatic do_reset(input logic [NB-1:0] k);
        key_n = k;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        clear_counts();
    endtask

    // Edges until button[idx]==val, or -1 when the limit expires.
    task automatic measure(input int idx, input logic val, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            step(1);
            if (button[idx] == val) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int acc;
        int rem [NB];
        bit bounce_hi;

        vecs[0]  = '{2'b11,  4, 2'b00, 0};
        vecs[1]  = '{2'b10, 10, 2'b00, 0};
        vecs[2]  = '{2'b10,  1, 2'b01, 1};
        vecs[3]  = '{2'b10, 10, 2'b01, 0};
        vecs[4]  = '{2'b11, 10, 2'b01, 0};
        vecs[5]  = '{2'b11,  1, 2'b00, 0};
        vecs[6]  = '{2'b00, 11, 2'b11, 2};
        vecs[7]  = '{2'b10, 11, 2'b01, 0};
        vecs[8]  = '{2'b11, 11, 2'b00, 0};
        vecs[9]  = '{2'b10,  5, 2'b00, 0};
        vecs[10] = '{2'b11,  5, 2'b00, 0};
        vecs[11] = '{2'b10, 11, 2'b01, 1};

        reset = 1'b1;
        key_n = '1;
        clear_counts();
        step(3);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_button", int'(button), 0);
        check("reset_press", int'(button_press), 0);

        // Table-driven segments.
        for (int v = 0; v < NV; v++) begin
            key_n = vecs[v].key_n;
            clear_counts();
            step(vecs[v].cycles);
            check($sformatf("vec%0d_button", v), int'(button), int'(vecs[v].exp_btn));
            check($sformatf("vec%0d_presses", v), pc[0] + pc[1], vecs[v].exp_press);
        end

        // Clean press: latency and a single pulse over 30 cycles.
        do_reset('1);
        key_n = 2'b10;
        measure(0, 1'b1, 30, n);
        check("clean_latency", n, 11);
        if (n > 0) step(30 - n);
        check("clean_presses", pc[0], 1);
        check("clean_held", int'(button[0]), 1);

        // Bounce every 3 cycles, then held low.
        do_reset('1);
        bounce_hi = 1'b0;
        for (int s = 0; s < 8; s++) begin
            key_n = {1'b1, logic'(s % 2)};
            for (int k = 0; k < 3; k++) begin
                step(1);
                bounce_hi |= button[0];
            end
        end
        check("bounce_stays_low", int'(bounce_hi), 0);
        key_n = 2'b10;
        measure(0, 1'b1, 30, n);
        check("bounce_latency", n, 11);

        // Release with a one-cycle re-press glitch at counter 5.
        do_reset('1);
        key_n = 2'b10;
        measure(0, 1'b1, 30, n);
        step(5);
        key_n = 2'b11;
        step(6);
        key_n = 2'b10;
        step(1);
        check("glitch_still_pressed", int'(button[0]), 1);
        key_n = 2'b11;
        measure(0, 1'b0, 30, n);
        check("release_latency", n, 11);

        // Simultaneous keys.
        do_reset('1);
        key_n = 2'b00;
        measure(0, 1'b1, 30, n);
        check("simul_latency", n, 11);
        check("simul_button", int'(button), 3);
        check("simul_press", int'(button_press), 3);

        // Reset while PRESSED with the key held.
        do_reset('1);
        key_n = 2'b10;
        measure(0, 1'b1, 30, n);
        step(3);
        reset = 1'b1;
        #1;
        check("reset_async_button", int'(button[0]), 0);
        step(2);
        reset = 1'b0;
        clear_counts();
        measure(0, 1'b1, 30, n);
        check("post_reset_latency", n, 11);
        check("post_reset_presses", pc[0], 1);

        // Long hold: repeat pulses only when auto-repeat is built in.
        do_reset('1);
        key_n = 2'b10;
        measure(0, 1'b1, 30, n);
        acc = cyc;
        step(70);
        check("hold_level", int'(button[0]), 1);
        if (press_times.size() > 0) check("hold_first_pulse", press_times[0], acc);
`ifdef BUTTON_AUTO_REPEAT_EN
        check("hold_pulse_count", press_times.size(), 4);
        if (press_times.size() == 4)
            for (int k = 1; k < 4; k++)
                check($sformatf("repeat_offset%0d", k), press_times[k] - press_times[0], RPT * k);
`else
        check("hold_pulse_count", press_times.size(), 1);
`endif

        // Random key activity with occasional resets, checked by the model.
        rem[0] = 3;
        rem[1] = 7;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (rem[i] == 0) begin
                    key_n[i] = ~key_n[i];
                    rem[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5))
                                                         : int'($urandom_range(9, 40));
                end else begin
                    rem[i]--;
                end
            end
            reset = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset = 1'b0;
        step(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
